// File: rtl/eq_band_sequencer_pkg.sv
// Shared types and constants for the eight-band equalizer sequencer.
// Holds the FSM state encoding, the config map, reset defaults and the output saturator.
package eq_band_sequencer_pkg;

    localparam int          NUM_BANDS     = 8;
    localparam logic [3:0]  CFG_ADDR_MASK = 4'd8;
    localparam logic [15:0] RST_GAIN      = 16'h4000;
    localparam logic [7:0]  RST_MASK      = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT,
        ST_MAC,
        ST_DONE
    } state_t;

    typedef logic signed [15:0] gain_t;

    // Clamp a 51-bit value to 32 bits. It fits only when bits 50:31 are all sign copies.
    function automatic logic [31:0] sat32(input logic [50:0] v);
        if (v[50:31] == '0 || v[50:31] == '1) begin
            return v[31:0];
        end
        return v[50] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

endpackage

// File: rtl/eq_band_sequencer_if.sv
// Configuration write port of the band sequencer.
// Writes are accepted on any cycle and never stall.
interface eq_band_sequencer_if;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata);
endinterface

// File: rtl/eq_mac_sat.sv
// 32x16 signed multiply-accumulate into 51 bits, plus a combinational shift-and-saturate output.
// The accumulator updates one cycle after en; y follows acc combinationally. There is no backpressure.
module eq_mac_sat
    import eq_band_sequencer_pkg::*;
#(
    parameter int GAIN_FRAC = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic signed [31:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] y
);

    logic signed [47:0] prod;
    logic signed [50:0] prod_ext;
    logic signed [50:0] acc;
    logic signed [50:0] shifted;

    assign prod     = a * b;
    assign prod_ext = {{3{prod[47]}}, prod};

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

    // The arithmetic shift floors toward -inf, so no rounding correction is applied.
    assign shifted = acc >>> GAIN_FRAC;
    assign y       = sat32(shifted);

endmodule

// File: rtl/eq_band_sequencer.sv
// Fires the enabled band filters, waits FILT_LAT cycles, then sums gain-weighted band outputs over 8 cycles.
// Result appears FILT_LAT+10 cycles after sample_stb. A strobe that arrives while busy is dropped and flagged in overrun.
module eq_band_sequencer
    import eq_band_sequencer_pkg::*;
#(
    parameter int FILT_LAT  = 2,
    parameter int GAIN_FRAC = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_stb,
    output logic               ena_1,
    output logic               ena_2,
    output logic               ena_3,
    output logic               ena_4,
    output logic               ena_5,
    output logic               ena_6,
    output logic               ena_7,
    output logic               ena_8,
    input  logic signed [31:0] y_in_1,
    input  logic signed [31:0] y_in_2,
    input  logic signed [31:0] y_in_3,
    input  logic signed [31:0] y_in_4,
    input  logic signed [31:0] y_in_5,
    input  logic signed [31:0] y_in_6,
    input  logic signed [31:0] y_in_7,
    input  logic signed [31:0] y_in_8,
    eq_band_sequencer_if.slave cfg,
    output logic signed [31:0] y_mix,
    output logic               y_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int             WCW       = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((FILT_LAT > 0) ? FILT_LAT - 1 : 0);

    state_t             state, state_nxt;
    gain_t              shadow_gain [NUM_BANDS];
    gain_t              act_gain    [NUM_BANDS];
    logic [7:0]         shadow_mask, act_mask;
    logic [WCW-1:0]     wait_cnt;
    logic [2:0]         band;
    logic [7:0]         ena;
    logic               mac_clr, mac_en;
    logic signed [31:0] y_sel, mac_y, y_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ena       = '0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state)
            ST_IDLE: if (sample_stb) state_nxt = ST_FIRE;
            ST_FIRE: begin
                ena = act_mask;
                if (FILT_LAT == 0) begin
                    state_nxt = ST_MAC;
                    mac_clr   = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: if (wait_cnt == WAIT_LAST) begin
                state_nxt = ST_MAC;
                mac_clr   = 1'b1;
            end
            ST_MAC: begin
                mac_en = act_mask[band];
                if (band == 3'(NUM_BANDS - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            band     <= '0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            band     <= (state == ST_MAC)  ? band + 1'b1     : '0;
        end
    end

    // Shadow takes writes at any time; the active copy is frozen per sample on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                shadow_gain[i] <= RST_GAIN;
                act_gain[i]    <= RST_GAIN;
            end
            shadow_mask <= RST_MASK;
            act_mask    <= RST_MASK;
        end else begin
            if (state == ST_IDLE && sample_stb) begin
                act_gain <= shadow_gain;
                act_mask <= shadow_mask;
            end
            if (cfg.cfg_we && !cfg.cfg_addr[3]) begin
                shadow_gain[cfg.cfg_addr[2:0]] <= cfg.cfg_wdata;
            end else if (cfg.cfg_we && cfg.cfg_addr == CFG_ADDR_MASK) begin
                shadow_mask <= cfg.cfg_wdata[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_stb && busy) begin
            overrun <= 1'b1;
        end else if (cfg.cfg_we && cfg.cfg_addr == CFG_ADDR_MASK) begin
            overrun <= 1'b0;
        end
    end

    always_comb begin
        y_sel = y_in_1;
        case (band)
            3'd0: y_sel = y_in_1;
            3'd1: y_sel = y_in_2;
            3'd2: y_sel = y_in_3;
            3'd3: y_sel = y_in_4;
            3'd4: y_sel = y_in_5;
            3'd5: y_sel = y_in_6;
            3'd6: y_sel = y_in_7;
            3'd7: y_sel = y_in_8;
        endcase
    end

    eq_mac_sat #(.GAIN_FRAC(GAIN_FRAC)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (y_sel),
        .b     (act_gain[band]),
        .y     (mac_y)
    );

    // y_mix shows the fresh result during DONE and is held afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_hold <= '0;
        end else if (state == ST_DONE) begin
            y_hold <= mac_y;
        end
    end

    assign y_mix   = (state == ST_DONE) ? mac_y : y_hold;
    assign y_valid = (state == ST_DONE);
    assign busy    = (state != ST_IDLE);

    assign {ena_8, ena_7, ena_6, ena_5, ena_4, ena_3, ena_2, ena_1} = ena;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Bench for eq_band_sequencer: directed samples, with a per-cycle check against a sample-level reference model.
module tb_eq_band_sequencer;
    import eq_band_sequencer_pkg::*;

    localparam int FL = 2;
    localparam int GF = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, sample_stb;
    logic               ena_1, ena_2, ena_3, ena_4, ena_5, ena_6, ena_7, ena_8;
    logic [7:0]         ena_v;
    logic signed [31:0] y_drv [8];
    logic signed [31:0] y_mix;
    logic               y_valid, busy, overrun;

    eq_band_sequencer_if cfg();

    eq_band_sequencer #(.FILT_LAT(FL), .GAIN_FRAC(GF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (sample_stb),
        .ena_1      (ena_1),
        .ena_2      (ena_2),
        .ena_3      (ena_3),
        .ena_4      (ena_4),
        .ena_5      (ena_5),
        .ena_6      (ena_6),
        .ena_7      (ena_7),
        .ena_8      (ena_8),
        .y_in_1     (y_drv[0]),
        .y_in_2     (y_drv[1]),
        .y_in_3     (y_drv[2]),
        .y_in_4     (y_drv[3]),
        .y_in_5     (y_drv[4]),
        .y_in_6     (y_drv[5]),
        .y_in_7     (y_drv[6]),
        .y_in_8     (y_drv[7]),
        .cfg        (cfg),
        .y_mix      (y_mix),
        .y_valid    (y_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    assign ena_v = {ena_8, ena_7, ena_6, ena_5, ena_4, ena_3, ena_2, ena_1};

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_n counts cycles since the sample was accepted (0 = idle).
    int                 m_n    = 0;
    logic               m_ovr  = 1'b0;
    logic [31:0]        m_exp  = '0;
    logic [31:0]        m_hold = '0;
    logic [7:0]         m_mask = 8'hFF;
    logic [7:0]         sh_mask = 8'hFF;
    logic signed [15:0] sh_gain [8];

    function automatic logic [31:0] mix_expect(input logic [7:0] mask);
        longint s = 0;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) s += longint'(y_drv[k]) * longint'(sh_gain[k]);
        end
        s = s >>> GF;
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_n    = 0;
            m_ovr  = 1'b0;
            m_hold = '0;
            sh_mask = 8'hFF;
            for (int k = 0; k < 8; k++) sh_gain[k] = 16'sh4000;
        end else begin
            if (m_n != 0) begin
                if (sample_stb) m_ovr = 1'b1;
                else if (cfg.cfg_we && cfg.cfg_addr == 4'd8) m_ovr = 1'b0;
                if (m_n == FL + 10) begin
                    m_hold = m_exp;
                    m_n    = 0;
                end else begin
                    m_n++;
                end
            end else begin
                if (cfg.cfg_we && cfg.cfg_addr == 4'd8) m_ovr = 1'b0;
                if (sample_stb) begin
                    m_mask = sh_mask;
                    m_exp  = mix_expect(sh_mask);
                    m_n    = 1;
                end
            end
            if (cfg.cfg_we && cfg.cfg_addr < 4'd8) sh_gain[cfg.cfg_addr[2:0]] = cfg.cfg_wdata;
            else if (cfg.cfg_we && cfg.cfg_addr == 4'd8) sh_mask = cfg.cfg_wdata[7:0];
        end
        #1;
        check("y_valid", 32'(y_valid), 32'(m_n == FL + 10));
        check("ena",     32'(ena_v),   (m_n == 1) ? 32'(m_mask) : 32'd0);
        check("busy",    32'(busy),    32'(m_n != 0));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("y_mix",   y_mix,        (m_n == FL + 10) ? m_exp : m_hold);
    end

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
        cfg.cfg_we    = 1'b1;
        cfg.cfg_addr  = addr;
        cfg.cfg_wdata = data;
        @(negedge clk);
        cfg.cfg_we    = 1'b0;
    endtask

    task automatic set_gains(input logic [15:0] g);
        for (int k = 0; k < 8; k++) cfg_write(4'(k), g);
    endtask

    task automatic set_y_all(input logic signed [31:0] v);
        for (int k = 0; k < 8; k++) y_drv[k] = v;
    endtask

    task automatic wait_valid(input string name, input int start, output int c);
        c = start;
        while (!y_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (c >= 40) check({name, "_timeout"}, 32'(c), 32'(FL + 10));
    endtask

    task automatic run_sample(input string name, input logic [31:0] exp_mix, input logic [7:0] exp_ena);
        int c;
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        check({name, "_ena"}, 32'(ena_v), 32'(exp_ena));
        wait_valid(name, 1, c);
        check({name, "_lat"}, 32'(c), 32'(FL + 10));
        check({name, "_mix"}, y_mix, exp_mix);
        @(negedge clk);
    endtask

    initial begin
        int c;
        int nvalid;
        rst_n = 1'b0;
        sample_stb = 1'b0;
        cfg.cfg_we = 1'b0;
        cfg.cfg_addr = '0;
        cfg.cfg_wdata = '0;
        set_y_all(32'sd1000);
        repeat (3) @(negedge clk);
        check("rst_y_mix", y_mix, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(y_valid), 32'd0);
        check("rst_ena", 32'(ena_v), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sample("dflt", 32'd8000, 8'hFF);

        cfg_write(4'd8, 16'h0005);
        set_gains(16'h2000);
        set_y_all(32'sd999);
        y_drv[0] = 32'sd400;
        y_drv[2] = 32'sd400;
        run_sample("mask5", 32'd400, 8'h05);

        cfg_write(4'd8, 16'h00FF);
        set_gains(16'h7FFF);
        set_y_all(32'sh7FFF_FFFF);
        run_sample("sat_pos", 32'h7FFF_FFFF, 8'hFF);
        set_gains(16'h8000);
        run_sample("sat_neg", 32'h8000_0000, 8'hFF);

        set_gains(16'h0001);
        set_y_all(32'sd0);
        y_drv[0] = -32'sd1;
        run_sample("floor", 32'hFFFF_FFFF, 8'hFF);

        // Second strobe three cycles after the first is an overrun.
        set_gains(16'h4000);
        set_y_all(32'sd1000);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (2) @(negedge clk);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        nvalid = 0;
        repeat (30) begin
            @(negedge clk);
            if (y_valid) nvalid++;
        end
        check("ovr_valids", 32'(nvalid), 32'd1);
        check("ovr_set", 32'(overrun), 32'd1);
        cfg_write(4'd8, 16'hAAFF);
        check("ovr_clr", 32'(overrun), 32'd0);
        run_sample("mask_hi", 32'd8000, 8'hFF);

        // Gain write during MAC affects only the next sample.
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (4) @(negedge clk);
        cfg_write(4'd1, 16'h2000);
        wait_valid("midmac", 6, c);
        check("midmac_mix", y_mix, 32'd8000);
        @(negedge clk);
        run_sample("newgain", 32'd7500, 8'hFF);

        // A write in the same cycle as the strobe is not seen by that sample.
        sample_stb = 1'b1;
        cfg.cfg_we = 1'b1;
        cfg.cfg_addr = 4'd0;
        cfg.cfg_wdata = 16'h0000;
        @(negedge clk);
        sample_stb = 1'b0;
        cfg.cfg_we = 1'b0;
        wait_valid("samecyc", 1, c);
        check("samecyc_mix", y_mix, 32'd7500);
        @(negedge clk);
        cfg_write(4'd12, 16'h0000);
        run_sample("ign_addr", 32'd6500, 8'hFF);

        // Reset during WAIT aborts the sample and restores config defaults.
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(y_valid), 32'd0);
        check("abort_mix", y_mix, 32'd0);
        check("abort_ena", 32'(ena_v), 32'd0);
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (y_valid) nvalid++;
        end
        check("abort_valids", 32'(nvalid), 32'd0);
        run_sample("post_rst", 32'd8000, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eq_band_sequencer.md
EQ_BAND_SEQUENCER -- requirements
Module: eq_band_sequencer

Interface
REQ-001 Parameter: FILT_LAT, default 2, cycles from ena pulse to valid y_in_k at the band filters.
REQ-002 Parameter: GAIN_FRAC, default 14, fractional bits of signed band gains (Q1.14).
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: sample_stb  input  1  one-cycle strobe, new x_in sample present at filter bank.
REQ-006 Port: ena_1..ena_8  output  1 each  per-band filter enable pulses.
REQ-007 Port: y_in_1..y_in_8  input  32 each  signed band filter outputs.
REQ-008 Port: cfg_we  input  1  config write strobe.
REQ-009 Port: cfg_addr  input  4  0-7 gain of band 1-8; 8 band enable mask; 9-15 ignored.
REQ-010 Port: cfg_wdata  input  16  write data (signed gain, or mask in bits 7:0).
REQ-011 Port: y_mix  output  32  signed equalized sample.
REQ-012 Port: y_valid  output  1  one-cycle strobe, y_mix updated.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: overrun  output  1  sticky, sample_stb received while busy.

Function
REQ-015 FSM states IDLE, FIRE, WAIT, MAC, DONE; IDLE -> FIRE on sample_stb.
REQ-016 On IDLE->FIRE, shadow registers (8 gains, mask) are copied to active registers; active set is constant for the whole sample.
REQ-017 FIRE lasts 1 cycle: ena_k = active_mask[k-1] for that cycle only; all ena_k low in every other state.
REQ-018 WAIT lasts exactly FILT_LAT cycles (WAIT skipped when FILT_LAT = 0), then MAC.
REQ-019 MAC lasts 8 cycles, band index 1..8 in order; each cycle acc += y_in_k * gain_k (32x16 signed, 48-bit product), disabled band adds 0.
REQ-020 Accumulator 51 bits signed, cleared on entry to MAC; no internal overflow possible.
REQ-021 DONE lasts 1 cycle: y_mix <= saturate32(acc >>> GAIN_FRAC, arithmetic shift, truncation toward -inf); y_valid = 1; next state IDLE.
REQ-022 Saturation: result > 2^31-1 -> 0x7FFFFFFF; result < -2^31 -> 0x80000000.
REQ-023 Latency sample_stb to y_valid = FILT_LAT + 10 cycles; back-to-back samples accepted once IDLE is re-entered (sample_stb in DONE cycle is an overrun).
REQ-024 sample_stb while busy: sample dropped, overrun set to 1, sequencing of current sample unaffected.
REQ-025 overrun cleared only by reset or a cfg write to address 8.
REQ-026 cfg writes accepted any cycle, update shadow registers only; write in the same cycle as sample_stb in IDLE is NOT seen by that sample.
REQ-027 Writes to cfg_addr 9-15 have no effect; mask uses cfg_wdata[7:0], bits 15:8 ignored.
REQ-028 y_mix holds its value between y_valid strobes.

Reset
REQ-029 With rst_n low at a clock edge: state IDLE, acc 0, y_mix 0, y_valid 0, busy 0, overrun 0, all ena_k 0.
REQ-030 Reset values of shadow/active config: all gains 0x4000 (unity), mask 0xFF.
REQ-031 Reset mid-sample aborts the sample; no y_valid issued for it.

Structure
REQ-032 Shared package holds FSM state typedef, band count (8), cfg address constants, reset gain/mask constants.
REQ-033 One sub-module, eq_mac_sat: 32x16 signed MAC, 51-bit accumulator, shift-and-saturate output.

Verification
REQ-034 Reset defaults, sample_stb, y_in_k all = 1000 -> y_valid at cycle 12 (FILT_LAT=2), y_mix = 8000, one ena pulse per band in FIRE cycle.
REQ-035 Mask 0x05, gains 0x2000, y_in_1=y_in_3=400, others 999 -> ena_1, ena_3 only; y_mix = 400.
REQ-036 All gains 0x7FFF, all y_in_k = 0x7FFFFFFF -> y_mix = 0x7FFFFFFF; gains 0x8000 same input -> 0x80000000.
REQ-037 sample_stb again 3 cycles after first -> overrun = 1, single y_valid, overrun cleared by cfg write to addr 8.
REQ-038 Gain write to band 2 during MAC -> current y_mix unchanged, next sample uses new gain.
REQ-039 rst_n low during WAIT -> no y_valid, all outputs at reset values next cycle.
